// File: rtl/pol2rect_pkg.sv
// Shared types and constants for the polar-to-rectangular CORDIC.
// Angles are 16-bit binary (65536 = 360 deg); x/y carry FRAC fractional bits.
package pol2rect_pkg;
    localparam int XY_W   = 18;
    localparam int ANG_W  = 16;
    localparam int OUT_W  = 9;
    localparam int ATAN_N = 12;

    localparam logic [15:0] INV_K = 16'd39797;

    typedef enum logic [1:0] {IDLE, ROT, DONE} state_e;

    typedef logic signed [XY_W-1:0]  xy_t;
    typedef logic signed [ANG_W-1:0] ang_t;

    function automatic ang_t atan_lut(input logic [3:0] i);
        case (i)
            4'd0:    atan_lut = 16'sd8192;
            4'd1:    atan_lut = 16'sd4836;
            4'd2:    atan_lut = 16'sd2555;
            4'd3:    atan_lut = 16'sd1297;
            4'd4:    atan_lut = 16'sd651;
            4'd5:    atan_lut = 16'sd326;
            4'd6:    atan_lut = 16'sd163;
            4'd7:    atan_lut = 16'sd81;
            4'd8:    atan_lut = 16'sd41;
            4'd9:    atan_lut = 16'sd20;
            4'd10:   atan_lut = 16'sd10;
            4'd11:   atan_lut = 16'sd5;
            default: atan_lut = '0;
        endcase
    endfunction
endpackage

// File: rtl/pol_to_rect_cordic_if.sv
// Input handshake and result strobe of the polar-to-rectangular converter.
interface pol_to_rect_cordic_if;
    logic                                      in_valid;
    logic                                      in_ready;
    logic [7:0]                                r_in;
    logic [7:0]                                theta_in;
    logic                                      out_valid;
    logic signed [pol2rect_pkg::OUT_W-1:0]     x_out;
    logic signed [pol2rect_pkg::OUT_W-1:0]     y_out;

    modport master (output in_valid, r_in, theta_in,
                    input  in_ready, out_valid, x_out, y_out);
    modport slave  (input  in_valid, r_in, theta_in,
                    output in_ready, out_valid, x_out, y_out);
endinterface

// File: rtl/pol2rect_cordic_iter.sv
// One rotation-mode CORDIC micro-rotation: drives z toward zero.
module pol2rect_cordic_iter
    import pol2rect_pkg::*;
(
    input  xy_t        x_i,
    input  xy_t        y_i,
    input  ang_t       z_i,
    input  logic [3:0] i_i,
    output xy_t        x_o,
    output xy_t        y_o,
    output ang_t       z_o
);
    xy_t  xs, ys;
    ang_t at;

    assign xs = x_i >>> i_i;
    assign ys = y_i >>> i_i;
    assign at = atan_lut(i_i);

    always_comb begin
        if (z_i[ANG_W-1]) begin
            x_o = x_i + ys;
            y_o = y_i - xs;
            z_o = z_i + at;
        end else begin
            x_o = x_i - ys;
            y_o = y_i + xs;
            z_o = z_i - at;
        end
    end
endmodule

// File: rtl/pol_to_rect_cordic.sv
// Iterative polar -> rectangular converter: one CORDIC step per enabled clock,
// result strobed ITER+1 enabled clocks after the accepting edge.
module pol_to_rect_cordic
    import pol2rect_pkg::*;
#(
    parameter int ITER = 12,
    parameter int FRAC = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    pol_to_rect_cordic_if.slave  bus
);
    localparam logic signed [XY_W:0] HALF   = (XY_W+1)'(1 << (FRAC-1));
    localparam logic signed [XY_W:0] SAT_HI = (XY_W+1)'(255);
    localparam logic signed [XY_W:0] SAT_LO = -(XY_W+1)'(255);

    state_e                    state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    xy_t                       x_q, x_d, y_q, y_d, x_n, y_n, x_init;
    ang_t                      z_q, z_d, z_n, z_init;
    logic signed [OUT_W-1:0]   xo_q, xo_d, yo_q, yo_d;
    logic                      ov_q, ov_d;
    logic [23:0]               prod;
    logic                      fold;

    function automatic logic signed [OUT_W-1:0] round_sat(input xy_t v);
        logic signed [XY_W:0] t;
        t = (XY_W+1)'(v) + HALF;
        t = t >>> FRAC;
        if (t > SAT_HI)      round_sat = SAT_HI[OUT_W-1:0];
        else if (t < SAT_LO) round_sat = SAT_LO[OUT_W-1:0];
        else                 round_sat = t[OUT_W-1:0];
    endfunction

    // Quadrants 2 and 3 are folded by negating x and rotating z by 180 deg,
    // which leaves |z| <= 90 deg, inside the CORDIC convergence range.
    assign fold   = bus.theta_in[7] ^ bus.theta_in[6];
    assign prod   = 24'(bus.r_in) * 24'(INV_K);
    assign x_init = xy_t'(prod >> (16-FRAC));
    assign z_init = {bus.theta_in ^ {fold, 7'd0}, 8'h00};

    pol2rect_cordic_iter u_iter (
        .x_i (x_q), .y_i (y_q), .z_i (z_q), .i_i (cnt_q),
        .x_o (x_n), .y_o (y_n), .z_o (z_n)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ena) begin
            case (state_q)
                IDLE:    if (bus.in_valid) state_d = ROT;
                ROT:     if (cnt_q == 4'(ITER-1)) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready = (state_q == IDLE) && !rst;
    end

    always_comb begin
        x_d = x_q; y_d = y_q; z_d = z_q; cnt_d = cnt_q;
        xo_d = xo_q; yo_d = yo_q; ov_d = ov_q;
        // A frozen strobe stays asserted; it only clears on an enabled edge.
        if (ena) begin
            ov_d = 1'b0;
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    x_d   = fold ? -x_init : x_init;
                    y_d   = '0;
                    z_d   = z_init;
                    cnt_d = '0;
                end
                ROT: begin
                    x_d   = x_n;
                    y_d   = y_n;
                    z_d   = z_n;
                    cnt_d = (cnt_q == 4'(ITER-1)) ? 4'd0 : cnt_q + 4'd1;
                end
                DONE: begin
                    xo_d = round_sat(x_q);
                    yo_d = round_sat(y_q);
                    ov_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0; y_q <= '0; z_q <= '0; cnt_q <= '0;
            xo_q <= '0; yo_q <= '0; ov_q <= 1'b0;
        end else begin
            x_q <= x_d; y_q <= y_d; z_q <= z_d; cnt_q <= cnt_d;
            xo_q <= xo_d; yo_q <= yo_d; ov_q <= ov_d;
        end
    end

    assign bus.out_valid = ov_q;
    assign bus.x_out     = xo_q;
    assign bus.y_out     = yo_q;
endmodule

// File: tb/tb_pol_to_rect_cordic.sv
// Directed-vector bench for pol_to_rect_cordic: table of (r, theta) -> (x, y)
// plus hand-written sequences for enable, back-pressure and reset corners.
module tb_pol_to_rect_cordic;
    logic clk = 1'b0;
    logic rst, ena;
    always #5 clk = ~clk;

    pol_to_rect_cordic_if bus();
    pol_to_rect_cordic #(.ITER(12), .FRAC(6)) dut (
        .clk (clk), .rst (rst), .ena (ena), .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] r;
        logic [7:0] th;
        int         ex;
        int         ey;
        int         tol;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp, input int tol);
        n_cmp++;
        if (act > exp + tol || act < exp - tol) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d +/- %0d", nm, act, exp, tol);
        end
    endtask

    task automatic start(input logic [7:0] r, input logic [7:0] th);
        int w = 0;
        bus.r_in = r; bus.theta_in = th; bus.in_valid = 1'b1;
        while (!bus.in_ready && w < 40) begin tick(); w++; end
        chk("in_ready_before_accept", int'(bus.in_ready), 1, 0);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Waits for the strobe; rdy_hi reports in_ready seen high before it.
    task automatic wait_out(output int lat, output int x, output int y, output int rdy_hi);
        lat = 0; rdy_hi = 0;
        do begin
            tick(); lat++;
            if (!bus.out_valid && bus.in_ready) rdy_hi = 1;
        end while (!bus.out_valid && lat < 60);
        if (!bus.out_valid) chk("strobe_timeout", 0, 1, 0);
        x = int'(bus.x_out);
        y = int'(bus.y_out);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        int lat, x, y, rdy, strobes, xs, ys, ex, ey;
        real rr, ang, tq;
        int ri, thi, xr, yr;

        vecs[0]  = '{8'd100, 8'd0,   100,    0, 2};
        vecs[1]  = '{8'd100, 8'd64,    0,  100, 2};
        vecs[2]  = '{8'd100, 8'd128, -100,   0, 2};
        vecs[3]  = '{8'd100, 8'd192,   0, -100, 2};
        vecs[4]  = '{8'd255, 8'd32,  180,  180, 2};
        vecs[5]  = '{8'd255, 8'd160, -180, -180, 2};
        vecs[6]  = '{8'd0,   8'd77,    0,    0, 0};
        vecs[7]  = '{8'd0,   8'd200,   0,    0, 0};
        vecs[8]  = '{8'd255, 8'd0,   254,    0, 1};
        vecs[9]  = '{8'd50,  8'd96,  -35,   35, 2};
        vecs[10] = '{8'd200, 8'd224, 141, -141, 2};
        vecs[11] = '{8'd255, 8'd192,   0, -254, 1};

        rst = 1'b1; ena = 1'b1;
        bus.in_valid = 1'b0; bus.r_in = '0; bus.theta_in = '0;
        #12;
        chk("rst_in_ready", int'(bus.in_ready), 0, 0);
        chk("rst_out_valid", int'(bus.out_valid), 0, 0);
        chk("rst_x", int'(bus.x_out), 0, 0);
        chk("rst_y", int'(bus.y_out), 0, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", int'(bus.in_ready), 1, 0);

        foreach (vecs[k]) begin
            start(vecs[k].r, vecs[k].th);
            wait_out(lat, x, y, rdy);
            chk($sformatf("vec%0d_latency", k), lat, 13, 0);
            chk($sformatf("vec%0d_rdy_low", k), rdy, 0, 0);
            chk($sformatf("vec%0d_x", k), x, vecs[k].ex, vecs[k].tol);
            chk($sformatf("vec%0d_y", k), y, vecs[k].ey, vecs[k].tol);
            tick();
            chk($sformatf("vec%0d_strobe_1cyc", k), int'(bus.out_valid), 0, 0);
        end

        // Second in_valid during ROT must be ignored.
        start(8'd100, 8'd0);
        tick(); tick();
        bus.in_valid = 1'b1; bus.r_in = 8'd200; bus.theta_in = 8'd64;
        tick(); tick();
        bus.in_valid = 1'b0;
        strobes = 0; xs = 0; ys = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.out_valid) begin strobes++; xs = int'(bus.x_out); ys = int'(bus.y_out); end
        end
        chk("busy_strobes", strobes, 1, 0);
        chk("busy_x", xs, 100, 2);
        chk("busy_y", ys, 0, 2);

        // ena low for 5 cycles mid-ROT stretches latency by 5.
        start(8'd100, 8'd64);
        for (int c = 0; c < 4; c++) tick();
        ena = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        ena = 1'b1;
        wait_out(lat, x, y, rdy);
        chk("ena_latency", lat + 9, 18, 0);
        chk("ena_x", x, 0, 2);
        chk("ena_y", y, 100, 2);

        // Strobe pending/held across ena low.
        tick();
        start(8'd255, 8'd32);
        for (int c = 0; c < 12; c++) tick();
        ena = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        chk("hold_no_early_strobe", int'(bus.out_valid), 0, 0);
        ena = 1'b1; tick();
        chk("hold_strobe", int'(bus.out_valid), 1, 0);
        chk("hold_x", int'(bus.x_out), 180, 2);
        ena = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        chk("hold_strobe_frozen", int'(bus.out_valid), 1, 0);
        ena = 1'b1; tick();
        chk("hold_strobe_clears", int'(bus.out_valid), 0, 0);

        // Reset mid-ROT aborts without a strobe.
        start(8'd255, 8'd160);
        for (int c = 0; c < 6; c++) tick();
        rst = 1'b1; #1;
        chk("abort_in_ready", int'(bus.in_ready), 0, 0);
        chk("abort_out_valid", int'(bus.out_valid), 0, 0);
        chk("abort_x", int'(bus.x_out), 0, 0);
        chk("abort_y", int'(bus.y_out), 0, 0);
        tick(); tick();
        rst = 1'b0; #1;
        chk("abort_rdy_back", int'(bus.in_ready), 1, 0);
        strobes = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.out_valid) strobes++;
        end
        chk("abort_no_strobe", strobes, 0, 0);

        // Round trip: (x,y) -> quantized (r,theta) -> converter, against real trig.
        for (int k = 0; k < 8; k++) begin
            xr = int'($urandom_range(360)) - 180;
            yr = int'($urandom_range(360)) - 180;
            rr = $sqrt(real'(xr * xr + yr * yr));
            ri = int'(rr);
            if (ri > 255) ri = 255;
            ang = $atan2(real'(yr), real'(xr));
            thi = ((int'(ang * 128.0 / 3.14159265358979) % 256) + 256) % 256;
            tq  = real'(thi) * 3.14159265358979 / 128.0;
            ex  = int'(real'(ri) * $cos(tq));
            ey  = int'(real'(ri) * $sin(tq));
            start(8'(ri), 8'(thi));
            wait_out(lat, x, y, rdy);
            chk($sformatf("rt%0d_x(r=%0d,th=%0d)", k, ri, thi), x, ex, 2);
            chk($sformatf("rt%0d_y(r=%0d,th=%0d)", k, ri, thi), y, ey, 2);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pol_to_rect_cordic.md
Name: pol_to_rect_cordic

Overview:
Converts a polar magnitude/angle pair (r, theta) into rectangular signed coordinates (x, y). It is the inverse of the team's existing rect-to-cylindrical magnitude block. The block uses an iterative, one-iteration-per-clock CORDIC in rotation mode, with a valid/ready input handshake and a one-cycle output strobe. It sits next to the magnitude block on the same 8-bit tile I/O so that round-trip checks (x,y -> r -> x,y) are possible.

Parameters:
ITER, 12, number of CORDIC iterations (legal range 8..12; the atan table holds 12 entries).
FRAC, 6, fractional bits carried in the internal x/y datapath.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
ena  input  1  global enable; when low, all state and outputs hold (no progress, no strobes)
in_valid  input  1  r_in/theta_in are valid this cycle
in_ready  output  1  high in IDLE only; a transfer occurs when in_valid && in_ready && ena
r_in  input  8  unsigned magnitude, 0..255
theta_in  input  8  binary angle, LSB = 360/256 deg (0 = 0 deg, 64 = 90 deg, 128 = 180 deg, 192 = 270 deg)
out_valid  output  1  one-cycle strobe: x_out/y_out updated this cycle
x_out  output  9  signed two's complement, saturated to -255..+255, held until the next result
y_out  output  9  signed two's complement, saturated to -255..+255, held until the next result

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=0 while rst is asserted and 1 after, out_valid=0, x_out=0, y_out=0, iteration counter=0, internal x/y/z=0.
- FSM states are IDLE, ROT and DONE.
- IDLE -> ROT on the accepting edge:
  - x := (r_in*INV_K) >> (16-FRAC), with INV_K = 39797 (Q0.16, 1/1.64676); y := 0.
  - z := {theta_in, 8'h00} as a signed 16-bit angle (65536 = 360 deg).
  - Quadrant fold: if theta_in[7:6] is 01 or 10, then x := -x and z := z - 32768 (mod 2^16). After the fold, |z| <= 90 deg.
- ROT: each enabled edge performs iteration i = 0..ITER-1:
  - d = +1 if z >= 0, else -1.
  - x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*ATAN[i].
  - Shifts are arithmetic. The internal x/y width is 18 bits signed, so no overflow is possible.
- After the iteration with i = ITER-1, go to DONE.
- DONE (one cycle): x_out/y_out := round-half-up(x >> FRAC) and round-half-up(y >> FRAC), each saturated to ±255. out_valid=1 for exactly this cycle, then return to IDLE.
- Latency: the result is strobed ITER+1 enabled clocks after the accepting edge (13 clocks at the defaults). Throughput is one conversion per ITER+2 clocks.
- in_valid while not in IDLE is ignored; there is no queueing.
- If ena goes low mid-operation, the FSM freezes. An out_valid that is already asserted stays high until ena returns and the DONE cycle completes. Never drop or duplicate the strobe.
- Asserting rst mid-operation aborts immediately to the reset values; no strobe is produced for the aborted conversion.
- r_in=0 yields exactly x_out=0, y_out=0.
- Accuracy: |error| <= 2 LSB on each output over all r_in and theta_in.

Decomposition:
- Package pol2rect_pkg holds:
  - ATAN table, 16-bit, i=0..11: 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5.
  - INV_K = 39797.
  - The state encoding (IDLE, ROT, DONE).
  - Width constants: internal XY width 18, angle width 16, output width 9.
- One combinational sub-module, pol2rect_cordic_iter: one rotation step taking (x, y, z, i) and returning (x', y', z'). The top level holds the FSM, counter, registers, fold and output rounding/saturation.

Test Plan:
- Rotate a single vector: r=100, theta=0 -> out_valid exactly 13 clocks after acceptance; x=100±2, y=0±2; in_ready low throughout.
- Quadrant boundaries at r=100: theta=64 -> (0, 100); theta=128 -> (-100, 0); theta=192 -> (0, -100); all ±2.
- Diagonal and saturation checks: r=255, theta=32 -> (180, 180)±2; r=255, theta=160 -> (-180, -180)±2; no output ever exceeds ±255.
- Zero and back-pressure: r=0 at any theta -> exactly (0, 0). A second in_valid pulse during ROT is ignored: one strobe only, and the result matches the first operands.
- Enable and reset interruptions: drop ena for 5 cycles mid-ROT -> the result is unchanged and latency grows by 5. Assert rst at iteration 6 -> outputs 0, no strobe, and in_ready returns to 1 after rst deasserts.
- Round-trip sweep: for random (x, y) with |x|, |y| <= 180, feed the magnitude block's r and a reference theta -> the reconstructed (x, y) is within ±3 of the original.
